// File: rtl/soundweb_pkg.sv
// soundweb_pkg
// Shared definitions for the Soundweb transmit path: framing byte values,
// the default maximum packet length and the sequencer state type.
package soundweb_pkg;

  localparam logic [7:0] STX              = 8'h02;
  localparam logic [7:0] ETX              = 8'h03;
  localparam int         MAX_PACKET_BYTES = 29;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage : soundweb_pkg

// File: rtl/soundweb_tx_sequencer.sv
// soundweb_tx_sequencer
// Takes an encoded Soundweb packet from a host register and streams it byte
// by byte to a UART over a valid/ready handshake.  The packet is frozen into a
// snapshot when transmission starts, so later host writes cannot corrupt the
// bytes in flight.  A packet must begin with STX and normally ends at the
// first ETX after byte 0; running off the end of the buffer is an overrun.
//
// Ports
//   clk         system clock (50 MHz)
//   reset_n     asynchronous active-low reset
//   start       host level; a rising edge requests a transmission
//   abort       host level; high terminates a packet in progress
//   packet      encoded packet, byte i at [8i+7:8i], byte 0 sent first
//   tx_data     byte offered to the UART
//   tx_valid    tx_data is valid
//   tx_ready    UART accepts tx_data when tx_valid and tx_ready are both high
//   busy        packet in progress
//   done        sticky: last packet ended with ETX
//   error       sticky: last packet was rejected, overran, or was aborted
//   byte_count  bytes accepted by the UART for the current or last packet
module soundweb_tx_sequencer
  import soundweb_pkg::*;
#(
  parameter int GAP_CYCLES = 0,
  parameter int MAX_BYTES  = MAX_PACKET_BYTES
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [8*MAX_BYTES-1:0] packet,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [4:0]             byte_count
);

  localparam int IDX_W = $clog2(MAX_BYTES + 1);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t                 state_r, state_nxt_s;
  logic                   start_q_r;
  logic [8*MAX_BYTES-1:0] snapshot_r, snapshot_nxt_s;
  logic [IDX_W-1:0]       index_r, index_nxt_s;
  logic [GAP_W-1:0]       gap_cnt_r, gap_cnt_nxt_s;
  logic [7:0]             tx_data_r, tx_data_nxt_s;
  logic                   tx_valid_r, tx_valid_nxt_s;
  logic                   busy_r;
  logic                   done_r, done_nxt_s;
  logic                   error_r, error_nxt_s;
  logic [4:0]             byte_count_r, byte_count_nxt_s;

  logic                   rise_s;
  logic                   hs_s;
  logic                   last_idx_s;

  assign rise_s     = start & ~start_q_r;
  // tx_valid_r is high exactly in SEND, and tx_data_r is the byte on offer.
  assign hs_s       = tx_valid_r & tx_ready;
  assign last_idx_s = (index_r == IDX_W'(MAX_BYTES - 1));

  // Next-state, snapshot, counters and status flags.
  always_comb begin
    state_nxt_s      = state_r;
    snapshot_nxt_s   = snapshot_r;
    index_nxt_s      = index_r;
    gap_cnt_nxt_s    = gap_cnt_r;
    done_nxt_s       = done_r;
    error_nxt_s      = error_r;
    byte_count_nxt_s = byte_count_r;

    case (state_r)
      ST_IDLE: begin
        // abort in IDLE only suppresses the capture.
        if (rise_s && !abort) begin
          snapshot_nxt_s   = packet;
          done_nxt_s       = 1'b0;
          error_nxt_s      = 1'b0;
          byte_count_nxt_s = 5'd0;
          index_nxt_s      = '0;
          gap_cnt_nxt_s    = '0;
          if (packet[7:0] == STX) begin
            state_nxt_s = ST_SEND;
          end else begin
            error_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_SEND: begin
        if (hs_s) begin
          if (byte_count_r < 5'(MAX_BYTES)) begin
            byte_count_nxt_s = byte_count_r + 5'd1;
          end else begin
            byte_count_nxt_s = byte_count_r;
          end
          if ((tx_data_r == ETX) && (index_r != '0)) begin
            done_nxt_s  = 1'b1;
            state_nxt_s = ST_IDLE;
          end else if (last_idx_s) begin
            error_nxt_s = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            index_nxt_s = index_r + IDX_W'(1);
            if (GAP_CYCLES > 0) begin
              gap_cnt_nxt_s = '0;
              state_nxt_s   = ST_GAP;
            end else begin
              state_nxt_s = ST_SEND;
            end
          end
        end else begin
          state_nxt_s = ST_SEND;
        end
      end

      ST_GAP: begin
        if (gap_cnt_r == GAP_W'(GAP_CYCLES - 1)) begin
          gap_cnt_nxt_s = '0;
          state_nxt_s   = ST_SEND;
        end else begin
          gap_cnt_nxt_s = gap_cnt_r + GAP_W'(1);
        end
      end

      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    // Abort overrides whatever the handshake decided, after the byte counted.
    if (abort && (state_r != ST_IDLE)) begin
      state_nxt_s = ST_IDLE;
      error_nxt_s = 1'b1;
      done_nxt_s  = 1'b0;
    end else begin
      state_nxt_s = state_nxt_s;
    end

    // Outputs are computed from next-state values so they can be registered
    // and still present byte 0 one cycle after the capture edge.
    tx_valid_nxt_s = (state_nxt_s == ST_SEND);
    tx_data_nxt_s  = snapshot_nxt_s[8*index_nxt_s +: 8];
  end

  // State, data path and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      start_q_r    <= 1'b0;
      snapshot_r   <= '0;
      index_r      <= '0;
      gap_cnt_r    <= '0;
      tx_data_r    <= 8'd0;
      tx_valid_r   <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      byte_count_r <= 5'd0;
    end else begin
      state_r      <= state_nxt_s;
      start_q_r    <= start;
      snapshot_r   <= snapshot_nxt_s;
      index_r      <= index_nxt_s;
      gap_cnt_r    <= gap_cnt_nxt_s;
      tx_data_r    <= tx_data_nxt_s;
      tx_valid_r   <= tx_valid_nxt_s;
      busy_r       <= (state_nxt_s != ST_IDLE);
      done_r       <= done_nxt_s;
      error_r      <= error_nxt_s;
      byte_count_r <= byte_count_nxt_s;
    end
  end

  assign tx_data    = tx_data_r;
  assign tx_valid   = tx_valid_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign error      = error_r;
  assign byte_count = byte_count_r;

endmodule : soundweb_tx_sequencer

// File: tb/tb_soundweb_tx_sequencer.sv
// Testbench for soundweb_tx_sequencer.  dut0 uses the default parameters,
// dut1 uses GAP_CYCLES=2.  Stimulus pushes the expected bytes into a queue per
// DUT; a monitor pops and compares on every handshake and checks that an
// offered byte stays stable while the UART stalls.
module tb_soundweb_tx_sequencer;

  localparam int MB = 29;

  logic          clk;
  logic          reset_n;

  logic          start0, abort0, tx_ready0;
  logic [8*MB-1:0] packet0;
  logic [7:0]    tx_data0;
  logic          tx_valid0, busy0, done0, error0;
  logic [4:0]    byte_count0;

  logic          start1, abort1, tx_ready1;
  logic [8*MB-1:0] packet1;
  logic [7:0]    tx_data1;
  logic          tx_valid1, busy1, done1, error1;
  logic [4:0]    byte_count1;

  int checks   = 0;
  int failures = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  logic       held0_v, held1_v;
  logic [7:0] held0, held1;

  soundweb_tx_sequencer dut0 (
    .clk(clk), .reset_n(reset_n), .start(start0), .abort(abort0),
    .packet(packet0), .tx_data(tx_data0), .tx_valid(tx_valid0),
    .tx_ready(tx_ready0), .busy(busy0), .done(done0), .error(error0),
    .byte_count(byte_count0)
  );

  soundweb_tx_sequencer #(.GAP_CYCLES(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .abort(abort1),
    .packet(packet1), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .busy(busy1), .done(done1), .error(error1),
    .byte_count(byte_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard monitor: compares handshakes and stall stability on both DUTs.
  always @(negedge clk) begin
    if (!reset_n) begin
      held0_v <= 1'b0;
      held1_v <= 1'b0;
    end else begin
      if (held0_v && tx_valid0) begin
        checks++;
        if (tx_data0 !== held0) begin
          failures++;
          $display("FAIL dut0_hold got=%02h required=%02h", tx_data0, held0);
        end
      end
      if (tx_valid0 && tx_ready0) begin
        checks++;
        if (q0.size() == 0) begin
          failures++;
          $display("FAIL dut0_unexpected_byte got=%02h required=none", tx_data0);
        end else begin
          logic [7:0] e;
          e = q0.pop_front();
          if (tx_data0 !== e) begin
            failures++;
            $display("FAIL dut0_byte got=%02h required=%02h", tx_data0, e);
          end
        end
      end
      held0_v <= tx_valid0 && !tx_ready0;
      held0   <= tx_data0;

      if (held1_v && tx_valid1) begin
        checks++;
        if (tx_data1 !== held1) begin
          failures++;
          $display("FAIL dut1_hold got=%02h required=%02h", tx_data1, held1);
        end
      end
      if (tx_valid1 && tx_ready1) begin
        checks++;
        if (q1.size() == 0) begin
          failures++;
          $display("FAIL dut1_unexpected_byte got=%02h required=none", tx_data1);
        end else begin
          logic [7:0] e;
          e = q1.pop_front();
          if (tx_data1 !== e) begin
            failures++;
            $display("FAIL dut1_byte got=%02h required=%02h", tx_data1, e);
          end
        end
      end
      held1_v <= tx_valid1 && !tx_ready1;
      held1   <= tx_data1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  task automatic wait_idle0(input string name, input int budget);
    int n;
    n = 0;
    while (busy0 && n < budget) begin
      tick(1);
      n++;
    end
    check(name, {31'd0, busy0}, 32'd0);
  endtask

  initial begin
    reset_n   = 1'b0;
    start0    = 1'b0; abort0 = 1'b0; tx_ready0 = 1'b0; packet0 = '0;
    start1    = 1'b0; abort1 = 1'b0; tx_ready1 = 1'b0; packet1 = '0;
    tick(3);
    check("rst_valid", {31'd0, tx_valid0}, 32'd0);
    check("rst_busy",  {31'd0, busy0}, 32'd0);
    check("rst_done",  {31'd0, done0}, 32'd0);
    check("rst_error", {31'd0, error0}, 32'd0);
    check("rst_count", {27'd0, byte_count0}, 32'd0);
    check("rst_data",  {24'd0, tx_data0}, 32'd0);
    reset_n = 1'b1;
    tick(1);

    // Basic packet, UART always ready: four consecutive bytes.
    packet0 = '0;
    packet0[7:0] = 8'h02; packet0[15:8] = 8'h8C; packet0[23:16] = 8'h00; packet0[31:24] = 8'h03;
    tx_ready0 = 1'b1;
    q0.push_back(8'h02); q0.push_back(8'h8C); q0.push_back(8'h00); q0.push_back(8'h03);
    start0 = 1'b1;
    tick(1);
    check("basic_latency", {31'd0, tx_valid0}, 32'd1);
    check("basic_first",   {24'd0, tx_data0}, 32'h02);
    tick(4);
    check("basic_busy_5th", {31'd0, busy0}, 32'd0);
    check("basic_done",     {31'd0, done0}, 32'd1);
    check("basic_count",    {27'd0, byte_count0}, 32'd4);
    check("basic_drained",  q0.size(), 32'd0);
    start0 = 1'b0;
    tick(1);

    // Stall on byte 2 for three cycles.
    q0.push_back(8'h02); q0.push_back(8'h8C); q0.push_back(8'h00); q0.push_back(8'h03);
    start0 = 1'b1;
    tick(2);
    tx_ready0 = 1'b0;
    tick(3);
    check("stall_valid", {31'd0, tx_valid0}, 32'd1);
    check("stall_data",  {24'd0, tx_data0}, 32'h8C);
    tx_ready0 = 1'b1;
    wait_idle0("stall_timeout", 20);
    check("stall_done",    {31'd0, done0}, 32'd1);
    check("stall_count",   {27'd0, byte_count0}, 32'd4);
    check("stall_drained", q0.size(), 32'd0);
    start0 = 1'b0;
    tick(1);

    // Missing STX: rejected, nothing sent.
    packet0[7:0] = 8'h55;
    start0 = 1'b1;
    tick(1);
    check("nostx_error", {31'd0, error0}, 32'd1);
    check("nostx_busy",  {31'd0, busy0}, 32'd0);
    check("nostx_valid", {31'd0, tx_valid0}, 32'd0);
    check("nostx_done",  {31'd0, done0}, 32'd0);
    tick(2);
    check("nostx_count", {27'd0, byte_count0}, 32'd0);
    start0 = 1'b0;
    tick(1);

    // Full buffer with no ETX: overrun after 29 bytes.
    packet0[7:0] = 8'h02;
    q0.push_back(8'h02);
    for (int i = 1; i < MB; i++) begin
      packet0[8*i +: 8] = 8'(8'h10 + i);
      q0.push_back(8'(8'h10 + i));
    end
    start0 = 1'b1;
    tick(1);
    wait_idle0("ovr_timeout", 60);
    check("ovr_error", {31'd0, error0}, 32'd1);
    check("ovr_done",  {31'd0, done0}, 32'd0);
    check("ovr_count", {27'd0, byte_count0}, 32'd29);
    tick(3);
    check("ovr_drained", q0.size(), 32'd0);
    start0 = 1'b0;
    tick(1);

    // Abort coincident with the third handshake; a rise while busy is ignored.
    packet0 = '0;
    packet0[7:0] = 8'h02; packet0[15:8] = 8'h11; packet0[23:16] = 8'h22;
    packet0[31:24] = 8'h33; packet0[39:32] = 8'h44; packet0[47:40] = 8'h03;
    q0.push_back(8'h02); q0.push_back(8'h11); q0.push_back(8'h22);
    start0 = 1'b1;
    tick(1);
    start0 = 1'b0;
    tick(1);
    start0 = 1'b1;
    tick(1);
    abort0 = 1'b1;
    tick(1);
    abort0 = 1'b0;
    check("abort_valid", {31'd0, tx_valid0}, 32'd0);
    check("abort_busy",  {31'd0, busy0}, 32'd0);
    check("abort_error", {31'd0, error0}, 32'd1);
    check("abort_done",  {31'd0, done0}, 32'd0);
    check("abort_count", {27'd0, byte_count0}, 32'd3);
    tick(3);
    check("abort_drained", q0.size(), 32'd0);
    start0 = 1'b0;
    tick(1);

    // Abort and rise together in IDLE: no capture, status untouched.
    abort0 = 1'b1;
    start0 = 1'b1;
    tick(1);
    abort0 = 1'b0;
    check("abrise_busy",  {31'd0, busy0}, 32'd0);
    check("abrise_count", {27'd0, byte_count0}, 32'd3);
    check("abrise_error", {31'd0, error0}, 32'd1);
    tick(1);
    check("abrise_busy2", {31'd0, busy0}, 32'd0);
    start0 = 1'b0;
    tick(1);

    // GAP_CYCLES=2 on dut1: valid pattern 1,0,0,1.
    packet1 = '0;
    packet1[7:0] = 8'h02; packet1[15:8] = 8'h03;
    tx_ready1 = 1'b1;
    q1.push_back(8'h02); q1.push_back(8'h03);
    start1 = 1'b1;
    tick(1);
    check("gap_v0", {31'd0, tx_valid1}, 32'd1);
    tick(1);
    check("gap_v1", {31'd0, tx_valid1}, 32'd0);
    tick(1);
    check("gap_v2", {31'd0, tx_valid1}, 32'd0);
    tick(1);
    check("gap_v3", {31'd0, tx_valid1}, 32'd1);
    tick(1);
    check("gap_done",    {31'd0, done1}, 32'd1);
    check("gap_busy",    {31'd0, busy1}, 32'd0);
    check("gap_count",   {27'd0, byte_count1}, 32'd2);
    check("gap_drained", q1.size(), 32'd0);
    start1 = 1'b0;
    tick(1);

    // Reset mid-packet drops tx_valid at once; start held through release
    // counts as a rise on the first clock afterwards.
    packet0 = '0;
    packet0[7:0] = 8'h02; packet0[15:8] = 8'h11; packet0[23:16] = 8'h22; packet0[31:24] = 8'h03;
    tx_ready0 = 1'b0;
    start0 = 1'b1;
    tick(2);
    check("pre_rst_valid", {31'd0, tx_valid0}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_valid", {31'd0, tx_valid0}, 32'd0);
    check("midrst_error", {31'd0, error0}, 32'd0);
    check("midrst_busy",  {31'd0, busy0}, 32'd0);
    tick(1);
    tx_ready0 = 1'b1;
    q0.push_back(8'h02); q0.push_back(8'h11); q0.push_back(8'h22); q0.push_back(8'h03);
    reset_n = 1'b1;
    tick(1);
    check("relrise_valid", {31'd0, tx_valid0}, 32'd1);
    wait_idle0("relrise_timeout", 20);
    check("relrise_done",    {31'd0, done0}, 32'd1);
    check("relrise_count",   {27'd0, byte_count0}, 32'd4);
    check("relrise_drained", q0.size(), 32'd0);
    start0 = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_soundweb_tx_sequencer
